param_data_buffer: RTL and testbench

Parametrised byte-circular data buffer between the USB packet path (one byte per transfer) and the host/AHB path (1–4 bytes per transfer). It is the successor to the fixed 64-byte endpoint buffer. New over the fixed version:
- Configurable depth
- True wrap-around pointers
- Full/empty/almost-full flags
- Rejection of over/under-run requests with error pulses
- Simultaneous read and write from opposite sides

---
 rtl/param_data_buffer_if.sv | 39 +++
 rtl/param_data_buffer.sv | 94 +++++++++
 tb/tb_param_data_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/param_data_buffer_if.sv
// Byte-buffer bus bundle between the USB packet side and the host side.
// The master drives requests; the slave is the buffer.
interface param_data_buffer_if #(
   parameter int DEPTH = 64,
   parameter int OCC_W = $clog2(DEPTH) + 1
);
   logic             clear;
   logic             store_rx_packet_data;
   logic [7:0]       rx_packet_data;
   logic             get_tx_packet_data;
   logic [7:0]       tx_packet_data;
   logic             store_tx_data;
   logic [31:0]      tx_data;
   logic             get_rx_data;
   logic [31:0]      rx_data;
   logic [1:0]       data_size;
   logic [OCC_W-1:0] buffer_occupancy;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             overflow_err;
   logic             underflow_err;

   modport master (
      output clear, store_rx_packet_data, rx_packet_data,
      output get_tx_packet_data, store_tx_data, tx_data,
      output get_rx_data, data_size,
      input  tx_packet_data, rx_data, buffer_occupancy,
      input  full, empty, almost_full, overflow_err, underflow_err
   );

   modport slave (
      input  clear, store_rx_packet_data, rx_packet_data,
      input  get_tx_packet_data, store_tx_data, tx_data,
      input  get_rx_data, data_size,
      output tx_packet_data, rx_data, buffer_occupancy,
      output full, empty, almost_full, overflow_err, underflow_err
   );
endinterface

// File: rtl/param_data_buffer.sv
// Circular byte buffer: 1-byte USB side, 1..4-byte host side,
// wrap-bit pointers, occupancy flags and registered error pulses.
module param_data_buffer #(
   parameter int DEPTH    = 64,
   parameter int AF_LEVEL = 56
) (
   input logic clk,
   input logic n_rst,
   param_data_buffer_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam int AW    = OCC_W - 1;

   logic [7:0]       mem_q [DEPTH];
   logic [OCC_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [OCC_W-1:0] occ, space;
   logic [2:0]       wr_n, rd_n;
   logic             wr_req, rd_req;
   logic             wr_ok, rd_ok;
   logic [AW-1:0]    wa [4];
   logic [AW-1:0]    ra [4];
   logic [7:0]       wb [4];

   always_comb begin
      occ    = wr_ptr_q - rd_ptr_q;
      space  = OCC_W'(DEPTH) - occ;
      wr_req = bus.store_tx_data | bus.store_rx_packet_data;
      rd_req = bus.get_rx_data | bus.get_tx_packet_data;
      wr_n   = bus.store_tx_data ? {1'b0, bus.data_size} + 3'd1 : 3'd1;
      rd_n   = bus.get_rx_data ? {1'b0, bus.data_size} + 3'd1 : 3'd1;
      // Both sides judged against start-of-cycle occupancy
      wr_ok  = !bus.clear && wr_req && (OCC_W'(wr_n) <= space);
      rd_ok  = !bus.clear && rd_req && (OCC_W'(rd_n) <= occ);
      ovf_d  = !bus.clear && wr_req && (OCC_W'(wr_n) > space);
      unf_d  = !bus.clear && rd_req && (OCC_W'(rd_n) > occ);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + OCC_W'(wr_n);
         if (rd_ok) rd_ptr_d = rd_ptr_q + OCC_W'(rd_n);
      end

      for (int k = 0; k < 4; k++) begin
         wa[k] = AW'(wr_ptr_q + OCC_W'(k));
         ra[k] = AW'(rd_ptr_q + OCC_W'(k));
         wb[k] = bus.store_tx_data ? bus.tx_data[8*k +: 8]
                                   : bus.rx_packet_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr_ok && (3'(k) < wr_n)) mem_q[wa[k]] <= wb[k];
      end
   end

   always_comb begin
      bus.tx_packet_data = (occ == '0) ? 8'h00 : mem_q[ra[0]];
      bus.rx_data        = '0;
      for (int k = 0; k < 4; k++) begin
         if ((2'(k) <= bus.data_size) && (OCC_W'(k) < occ))
            bus.rx_data[8*k +: 8] = mem_q[ra[k]];
      end
      bus.buffer_occupancy = occ;
      bus.full             = (occ == OCC_W'(DEPTH));
      bus.empty            = (occ == '0);
      bus.almost_full      = (occ >= OCC_W'(AF_LEVEL));
      bus.overflow_err     = ovf_q;
      bus.underflow_err    = unf_q;
   end
endmodule

// File: tb/tb_param_data_buffer.sv
// Directed bench for param_data_buffer (DEPTH=64, AF_LEVEL=56).
// Hand-computed expectations checked through one compare task.
module tb_param_data_buffer;
   logic clk;
   logic n_rst;
   int   nvec;
   int   nerr;

   param_data_buffer_if #(.DEPTH(64)) bus ();

   param_data_buffer #(
      .DEPTH(64),
      .AF_LEVEL(56)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.clear                = 1'b0;
      bus.store_rx_packet_data = 1'b0;
      bus.get_tx_packet_data   = 1'b0;
      bus.store_tx_data        = 1'b0;
      bus.get_rx_data          = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic put_byte(input logic [7:0] b);
      bus.store_rx_packet_data = 1'b1;
      bus.rx_packet_data       = b;
      step();
   endtask

   initial begin
      logic [7:0] e;
      nvec = 0;
      nerr = 0;
      n_rst = 1'b0;
      idle();
      bus.rx_packet_data = 8'h00;
      bus.tx_data        = 32'h0;
      bus.data_size      = 2'd3;
      #12;
      n_rst = 1'b1;
      step();

      // 1: reset state
      chk("rst_occ", 32'(bus.buffer_occupancy), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_af", 32'(bus.almost_full), 32'd0);
      chk("rst_tx", 32'(bus.tx_packet_data), 32'd0);
      chk("rst_rx", bus.rx_data, 32'd0);

      // 2: 4-byte host write, byte pops
      bus.store_tx_data = 1'b1;
      bus.data_size     = 2'd3;
      bus.tx_data       = 32'hDDCCBBAA;
      step();
      chk("t2_occ", 32'(bus.buffer_occupancy), 32'd4);
      for (int i = 0; i < 4; i++) begin
         e = 8'hAA + 8'(i * 17);
         bus.get_tx_packet_data = 1'b1;
         #1;
         chk("t2_byte", 32'(bus.tx_packet_data), 32'(e));
         step();
      end
      chk("t2_empty", 32'(bus.empty), 32'd1);

      // 3: packet writes, host reads, underflow
      for (int i = 0; i < 5; i++) put_byte(8'h11 + 8'(i));
      bus.get_rx_data = 1'b1;
      bus.data_size   = 2'd1;
      #1;
      chk("t3_rx2", bus.rx_data, 32'h00001211);
      step();
      chk("t3_occ3", 32'(bus.buffer_occupancy), 32'd3);
      bus.get_rx_data = 1'b1;
      bus.data_size   = 2'd3;
      #1;
      chk("t3_rx_part", bus.rx_data, 32'h00151413);
      step();
      chk("t3_unf", 32'(bus.underflow_err), 32'd1);
      chk("t3_occ_hold", 32'(bus.buffer_occupancy), 32'd3);
      step();
      chk("t3_unf_pulse", 32'(bus.underflow_err), 32'd0);

      // 4: fill from address 0, overflow, wrap
      n_rst = 1'b0;
      #1;
      n_rst = 1'b1;
      for (int i = 0; i < 64; i++) begin
         put_byte(8'(i));
         if (i == 54) chk("t4_af55", 32'(bus.almost_full), 32'd0);
         if (i == 55) chk("t4_af56", 32'(bus.almost_full), 32'd1);
         if (i == 62) chk("t4_full63", 32'(bus.full), 32'd0);
      end
      chk("t4_full", 32'(bus.full), 32'd1);
      put_byte(8'hEE);
      chk("t4_ovf", 32'(bus.overflow_err), 32'd1);
      chk("t4_occ64", 32'(bus.buffer_occupancy), 32'd64);
      chk("t4_head", 32'(bus.tx_packet_data), 32'd0);
      for (int i = 0; i < 3; i++) begin
         bus.get_tx_packet_data = 1'b1;
         #1;
         chk("t4_pop", 32'(bus.tx_packet_data), 32'(i));
         step();
      end
      bus.store_tx_data = 1'b1;
      bus.data_size     = 2'd2;
      bus.tx_data       = 32'h00C2C1C0;
      step();
      chk("t4_refull", 32'(bus.full), 32'd1);
      // Full: read accepted, write rejected
      bus.get_tx_packet_data   = 1'b1;
      bus.store_rx_packet_data = 1'b1;
      bus.rx_packet_data       = 8'h77;
      #1;
      chk("t4_rw_head", 32'(bus.tx_packet_data), 32'd3);
      step();
      chk("t4_rw_occ", 32'(bus.buffer_occupancy), 32'd63);
      chk("t4_rw_ovf", 32'(bus.overflow_err), 32'd1);
      for (int i = 0; i < 63; i++) begin
         e = (i < 60) ? 8'(4 + i) : 8'hC0 + 8'(i - 60);
         bus.get_tx_packet_data = 1'b1;
         #1;
         chk("t4_wrap", 32'(bus.tx_packet_data), 32'(e));
         step();
      end
      chk("t4_empty", 32'(bus.empty), 32'd1);

      // 5: simultaneous read+write, writer priority
      for (int i = 0; i < 10; i++) put_byte(8'h30 + 8'(i));
      bus.get_tx_packet_data = 1'b1;
      bus.store_tx_data      = 1'b1;
      bus.data_size          = 2'd2;
      bus.tx_data            = 32'h00A2A1A0;
      #1;
      chk("t5_head", 32'(bus.tx_packet_data), 32'h30);
      step();
      chk("t5_occ12", 32'(bus.buffer_occupancy), 32'd12);
      chk("t5_ovf", 32'(bus.overflow_err), 32'd0);
      chk("t5_unf", 32'(bus.underflow_err), 32'd0);
      bus.store_rx_packet_data = 1'b1;
      bus.rx_packet_data       = 8'h55;
      bus.store_tx_data        = 1'b1;
      bus.data_size            = 2'd0;
      bus.tx_data              = 32'h00000066;
      step();
      chk("t5_occ13", 32'(bus.buffer_occupancy), 32'd13);
      for (int i = 0; i < 13; i++) begin
         e = (i < 9)  ? 8'h31 + 8'(i) :
             (i < 12) ? 8'hA0 + 8'(i - 9) : 8'h66;
         bus.get_tx_packet_data = 1'b1;
         #1;
         chk("t5_order", 32'(bus.tx_packet_data), 32'(e));
         step();
      end
      chk("t5_empty", 32'(bus.empty), 32'd1);

      // 6: clear beats read; async reset mid-stream
      for (int i = 0; i < 20; i++) put_byte(8'(i));
      chk("t6_occ20", 32'(bus.buffer_occupancy), 32'd20);
      bus.clear       = 1'b1;
      bus.get_rx_data = 1'b1;
      bus.data_size   = 2'd3;
      step();
      chk("t6_clr_occ", 32'(bus.buffer_occupancy), 32'd0);
      chk("t6_clr_unf", 32'(bus.underflow_err), 32'd0);
      chk("t6_clr_empty", 32'(bus.empty), 32'd1);
      for (int i = 0; i < 5; i++) put_byte(8'h40 + 8'(i));
      chk("t6_occ5", 32'(bus.buffer_occupancy), 32'd5);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t6_ar_occ", 32'(bus.buffer_occupancy), 32'd0);
      chk("t6_ar_empty", 32'(bus.empty), 32'd1);
      chk("t6_ar_tx", 32'(bus.tx_packet_data), 32'd0);
      chk("t6_ar_rx", bus.rx_data, 32'd0);
      n_rst = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
